// File: rtl/ifu_lsu_arb.sv
// ifu_lsu_arb: arbitrates instruction fetches (IFU) and loads/stores (LSU)
// onto a single memory port with at most one outstanding transaction.
// The LSU wins contention unless the IFU has been passed over STARVE_MAX
// consecutive times, in which case the IFU is granted.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   ifu_req_val/rdy, ifu_addr           IFU request channel
//   ifu_rsp_val, ifu_rsp_data           IFU response channel
//   lsu_req_val/rdy, lsu_addr, lsu_wen,
//   lsu_wdata, lsu_wstrb                LSU request channel
//   lsu_rsp_val, lsu_rsp_data           LSU response channel
//   mem_req_val/rdy, mem_addr, mem_wen,
//   mem_wdata, mem_wstrb                memory request channel
//   mem_rsp_val, mem_rsp_data           memory response channel
module ifu_lsu_arb #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req_val,
  output logic            ifu_req_rdy,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_val,
  output logic [DW-1:0]   ifu_rsp_data,
  input  logic            lsu_req_val,
  output logic            lsu_req_rdy,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_rsp_val,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            mem_req_val,
  input  logic            mem_req_rdy,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rsp_val,
  input  logic [DW-1:0]   mem_rsp_data
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic            owner_lsu;
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;

  logic            starved;
  logic            grant_lsu;
  logic            grant_ifu;

  // Arbitration: LSU priority, IFU forced through once starvation saturates.
  assign starved   = (starve_cnt == CW'(STARVE_MAX));
  assign grant_lsu = (state == IDLE) && lsu_req_val && !(ifu_req_val && starved);
  assign grant_ifu = (state == IDLE) && ifu_req_val && !grant_lsu;

  assign ifu_req_rdy = grant_ifu;
  assign lsu_req_rdy = grant_lsu;

  // Memory request is driven straight from the captured fields.
  assign mem_req_val = (state == REQ);
  assign mem_addr    = r_addr;
  assign mem_wen     = r_wen;
  assign mem_wdata   = r_wdata;
  assign mem_wstrb   = r_wstrb;

  // Responses are steered to the owner only while waiting for one.
  assign ifu_rsp_val  = (state == RSP) && !owner_lsu && mem_rsp_val;
  assign lsu_rsp_val  = (state == RSP) &&  owner_lsu && mem_rsp_val;
  assign ifu_rsp_data = mem_rsp_data;
  assign lsu_rsp_data = mem_rsp_data;

  // FSM, request capture and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_lsu  <= 1'b0;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            state     <= REQ;
            owner_lsu <= 1'b1;
            r_addr    <= lsu_addr;
            r_wen     <= lsu_wen;
            r_wdata   <= lsu_wdata;
            r_wstrb   <= lsu_wstrb;
            // Only count grants that actually made the IFU wait.
            if (!ifu_req_val) begin
              starve_cnt <= '0;
            end else if (!starved) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end else if (grant_ifu) begin
            state      <= REQ;
            owner_lsu  <= 1'b0;
            r_addr     <= ifu_addr;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            starve_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_req_rdy) begin
            state <= RSP;
          end
        end
        RSP: begin
          if (mem_rsp_val) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifu_lsu_arb.md
IFU_LSU_ARB -- requirements
Module: ifu_lsu_arb

Interface
REQ-001 Parameters (name, default, meaning):
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, max consecutive LSU grants while IFU waits
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- ifu_req_val, in, 1, IFU fetch request valid
- ifu_req_rdy, out, 1, IFU request accepted
- ifu_addr, in, AW, fetch address
- ifu_rsp_val, out, 1, fetch data valid
- ifu_rsp_data, out, DW, fetched instruction
- lsu_req_val, in, 1, LSU request valid
- lsu_req_rdy, out, 1, LSU request accepted
- lsu_addr, in, AW, load/store address
- lsu_wen, in, 1, 1 = store
- lsu_wdata, in, DW, store data
- lsu_wstrb, in, DW/8, byte strobes
- lsu_rsp_val, out, 1, load data valid or store acknowledged
- lsu_rsp_data, out, DW, load data
- mem_req_val, out, 1, memory request valid
- mem_req_rdy, in, 1, memory accepts request
- mem_addr, out, AW, memory address
- mem_wen, out, 1, store flag
- mem_wdata, out, DW, store data
- mem_wstrb, out, DW/8, byte strobes
- mem_rsp_val, in, 1, memory response valid
- mem_rsp_data, in, DW, memory response data
REQ-003 Clock is clk and reset is rst_n: one clock, asynchronous active-low reset.

Function
REQ-004 Implement a three-state FSM with states IDLE, REQ and RSP, and at most one outstanding memory transaction.
REQ-005 In IDLE, assert the winner's req_rdy combinationally when any req_val is high; the loser's req_rdy stays 0; both rdy are 0 in REQ and RSP.
REQ-006 When a req_val/req_rdy handshake occurs, register the winner's addr, wen, wdata, wstrb and owner ID (IFU requests register wen=0, wstrb=0), then move to REQ.
REQ-007 In REQ, drive mem_req_val=1 with the registered fields; move to RSP on mem_req_rdy=1; hold the registered fields stable while mem_req_rdy=0.
REQ-008 In RSP, set the owner's rsp_val = mem_rsp_val and the owner's rsp_data = mem_rsp_data; the non-owner rsp_val is 0; move to IDLE in the same cycle mem_rsp_val=1.
REQ-009 Ignore mem_rsp_val outside RSP; no response is forwarded.
REQ-010 Minimum latency: handshake in cycle N, mem_req_val in N+1, rsp_val in N+2 if the memory accepts at once and responds the next cycle; the next handshake is no earlier than the IDLE cycle after the response.
REQ-011 Arbitration when both valid: the LSU wins unless starve_cnt == STARVE_MAX, in which case the IFU wins; a single valid requester always wins.
REQ-012 starve_cnt behaviour:
- increments, saturating at STARVE_MAX, on each LSU grant where ifu_req_val=1
- clears to 0 on any IFU grant
- clears to 0 on an LSU grant where ifu_req_val=0
- width is clog2(STARVE_MAX+1) bits
REQ-013 Store responses are forwarded through lsu_rsp_val like loads; lsu_rsp_data carries mem_rsp_data unmodified.
REQ-014 Requester fields are sampled only in the handshake cycle; later changes do not affect an in-flight transaction.

Reset
REQ-015 While rst_n=0, asynchronously force:
- state to IDLE
- starve_cnt to 0
- all registered request fields and the owner ID to 0
REQ-016 Outputs during and after reset until the first handshake: mem_req_val=0, both rsp_val=0, and mem_addr, mem_wen, mem_wdata and mem_wstrb all 0.
REQ-017 Reset asserted in REQ or RSP drops the transaction; a later mem_rsp_val is ignored per REQ-009.

Verification
REQ-018 IFU only, ifu_addr=0x80000000, mem_req_rdy=1, response 0x00000013 one cycle later -> mem_addr=0x80000000 at N+1, ifu_rsp_val=1 with data 0x00000013 at N+2, lsu_rsp_val=0 throughout.
REQ-019 Both valid in the same cycle with starve_cnt=0 -> lsu_req_rdy=1 and ifu_req_rdy=0; the LSU store (addr 0x100, wdata 0xDEADBEEF, wstrb 0xF) appears on mem_* with mem_wen=1.
REQ-020 Both valid continuously for 6 grants, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU; starve_cnt reads 0 after the IFU grant.
REQ-021 Backpressure: mem_req_rdy=0 for 3 cycles while ifu_addr changes -> mem_addr holds the captured value; both req_rdy stay 0.
REQ-022 Stray and reset cases:
- mem_rsp_val=1 in IDLE -> no rsp_val asserted
- rst_n pulsed low in RSP -> state IDLE, mem_req_val=0, and the next mem_rsp_val is ignored
